// File: rtl/board_sequencer_if.sv
// rtl/board_sequencer_if.sv - move strobe and board/status bundle between turn logic and board sequencer
interface board_sequencer_if;
    logic       move_valid;
    logic [3:0] location;
    logic [1:0] mark;
    logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic       busy;
    logic       illegal_move;
    logic       gameend;
    logic [1:0] winner;
    logic [3:0] fade_loc;

    modport master (
        output move_valid, location, mark,
        input  a0, a1, a2, a3, a4, a5, a6, a7, a8,
        input  busy, illegal_move, gameend, winner, fade_loc
    );

    modport slave (
        input  move_valid, location, mark,
        output a0, a1, a2, a3, a4, a5, a6, a7, a8,
        output busy, illegal_move, gameend, winner, fade_loc
    );
endinterface

// File: rtl/board_sequencer.sv
// rtl/board_sequencer.sv - elimination tic-tac-toe board owner: evict, place, win check
// Optional BOARD_FADE_HINT_EN: drive fade_loc with the next mover's cell due for eviction.
module board_sequencer #(
    parameter int MAX_MARKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    board_sequencer_if.slave bus
);
    localparam logic [1:0] MARK_X = 2'b10;
    localparam logic [1:0] MARK_O = 2'b01;
    localparam logic [1:0] LAST   = 2'(MAX_MARKS - 1);
    localparam logic [2:0] FULL   = 3'(MAX_MARKS);

    typedef enum logic [2:0] {S_IDLE, S_EVICT, S_PLACE, S_CHECK, S_END} state_t;

    state_t           state, state_n;
    logic [8:0][1:0]  cells;
    logic [3:0]       x_fifo [MAX_MARKS];
    logic [3:0]       o_fifo [MAX_MARKS];
    logic [1:0]       x_rd, x_wr, o_rd, o_wr;
    logic [2:0]       x_cnt, o_cnt;
    logic [3:0]       lat_loc;
    logic [1:0]       lat_mark;
    logic             illegal_q, gameend_q;
    logic [1:0]       winner_q;

    logic             legal, mover_full, win;
    logic             do_latch, do_evict, do_place, do_win, illegal_n;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic line_win(input logic [8:0][1:0] b, input logic [1:0] m);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (b[3*r] == m && b[3*r+1] == m && b[3*r+2] == m) hit = 1'b1;
            if (b[r] == m && b[r+3] == m && b[r+6] == m) hit = 1'b1;
        end
        if (b[0] == m && b[4] == m && b[8] == m) hit = 1'b1;
        if (b[2] == m && b[4] == m && b[6] == m) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        legal      = !gameend_q && (bus.mark == MARK_X || bus.mark == MARK_O) &&
                     (bus.location <= 4'd8) && (cells[bus.location] == 2'b00);
        mover_full = (bus.mark == MARK_X) ? (x_cnt == FULL) : (o_cnt == FULL);
        // Only the latched mover can have completed a line this move.
        win        = line_win(cells, lat_mark);
    end

    always_comb begin
        state_n   = state;
        do_latch  = 1'b0;
        do_evict  = 1'b0;
        do_place  = 1'b0;
        do_win    = 1'b0;
        illegal_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.move_valid) begin
                    if (legal) begin
                        do_latch = 1'b1;
                        state_n  = mover_full ? S_EVICT : S_PLACE;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
            end
            S_EVICT: begin
                do_evict = 1'b1;
                state_n  = S_PLACE;
            end
            S_PLACE: begin
                do_place = 1'b1;
                state_n  = S_CHECK;
            end
            S_CHECK: begin
                if (win) begin
                    do_win  = 1'b1;
                    state_n = S_END;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_END:   state_n = S_END;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cells     <= '0;
            x_rd      <= '0;
            x_wr      <= '0;
            o_rd      <= '0;
            o_wr      <= '0;
            x_cnt     <= '0;
            o_cnt     <= '0;
            lat_loc   <= '0;
            lat_mark  <= '0;
            illegal_q <= 1'b0;
            gameend_q <= 1'b0;
            winner_q  <= 2'b00;
            for (int i = 0; i < MAX_MARKS; i++) begin
                x_fifo[i] <= '0;
                o_fifo[i] <= '0;
            end
        end else begin
            illegal_q <= illegal_n;
            if (do_latch) begin
                lat_loc  <= bus.location;
                lat_mark <= bus.mark;
            end
            if (do_evict) begin
                if (lat_mark == MARK_X) begin
                    cells[x_fifo[x_rd]] <= 2'b00;
                    x_rd                <= ptr_inc(x_rd);
                    x_cnt               <= x_cnt - 3'd1;
                end else begin
                    cells[o_fifo[o_rd]] <= 2'b00;
                    o_rd                <= ptr_inc(o_rd);
                    o_cnt               <= o_cnt - 3'd1;
                end
            end
            if (do_place) begin
                cells[lat_loc] <= lat_mark;
                if (lat_mark == MARK_X) begin
                    x_fifo[x_wr] <= lat_loc;
                    x_wr         <= ptr_inc(x_wr);
                    x_cnt        <= x_cnt + 3'd1;
                end else begin
                    o_fifo[o_wr] <= lat_loc;
                    o_wr         <= ptr_inc(o_wr);
                    o_cnt        <= o_cnt + 3'd1;
                end
            end
            if (do_win) begin
                gameend_q <= 1'b1;
                winner_q  <= lat_mark;
            end
        end
    end

`ifdef BOARD_FADE_HINT_EN
    logic [3:0] fade_q;

    // Hint targets the player who moves next, i.e. the one who did not just move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fade_q <= 4'hF;
        end else if (state == S_CHECK) begin
            if (do_win)
                fade_q <= 4'hF;
            else if (lat_mark == MARK_X)
                fade_q <= (o_cnt == FULL) ? o_fifo[o_rd] : 4'hF;
            else
                fade_q <= (x_cnt == FULL) ? x_fifo[x_rd] : 4'hF;
        end
    end

    assign bus.fade_loc = fade_q;
`else
    assign bus.fade_loc = 4'hF;
`endif

    assign bus.a0           = cells[0];
    assign bus.a1           = cells[1];
    assign bus.a2           = cells[2];
    assign bus.a3           = cells[3];
    assign bus.a4           = cells[4];
    assign bus.a5           = cells[5];
    assign bus.a6           = cells[6];
    assign bus.a7           = cells[7];
    assign bus.a8           = cells[8];
    assign bus.busy         = (state != S_IDLE);
    assign bus.illegal_move = illegal_q;
    assign bus.gameend      = gameend_q;
    assign bus.winner       = winner_q;
endmodule
